probabilistic_search_sequencer: RTL

Controller that sequences the Metropolis-style acceptance loop of the probabilistic search. Per iteration it requests a proposed assignment from the sample block and presents current cost u and proposed cost v to the acceptance-probability block. It then steps that block's random generator once, samples the 1-bit accept decision, and commits or rejects the proposal. It also tracks the iteration count and terminates on a solved state (cost 0), on the iteration limit, or on abort.

---
 rtl/probabilistic_search_pkg.sv | 14 +
 rtl/probabilistic_search_sequencer_counter.sv | 26 ++
 rtl/probabilistic_search_sequencer.sv | 89 ++++++++
 3 files changed

// File: rtl/probabilistic_search_pkg.sv
// probabilistic_search_pkg: shared state encoding and widths for the search sequencer
package probabilistic_search_pkg;
  localparam int DEF_COST_WIDTH = 8;
  localparam int DEF_ITER_WIDTH = 16;
  localparam int COST_SOLVED = 0;
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQUEST,
    S_DECIDE,
    S_EVAL,
    S_CHECK,
    S_DONE
  } state_t;
endpackage

// File: rtl/probabilistic_search_sequencer_counter.sv
// search_iteration_counter: completed-iteration counter with latched limit and limit-reached flag
module search_iteration_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         at_limit
);
  logic [W-1:0] limit_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      limit_reg <= '0;
    end else if (load) begin
      count <= '0;
      limit_reg <= limit;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end
  assign at_limit = count == limit_reg;
endmodule

// File: rtl/probabilistic_search_sequencer.sv
// probabilistic_search_sequencer: sequences request/decide/evaluate/check of the Metropolis acceptance loop
module probabilistic_search_sequencer
  import probabilistic_search_pkg::*;
#(
  parameter int COST_WIDTH = DEF_COST_WIDTH,
  parameter int ITER_WIDTH = DEF_ITER_WIDTH
) (
  input  logic                  in_clock,
  input  logic                  in_reset_n,
  input  logic                  in_start,
  input  logic                  in_abort,
  input  logic [COST_WIDTH-1:0] in_initial_cost,
  input  logic [ITER_WIDTH-1:0] in_max_iter,
  output logic                  out_sample_req,
  input  logic                  in_sample_valid,
  input  logic [COST_WIDTH-1:0] in_proposed_cost,
  output logic [COST_WIDTH-1:0] out_u,
  output logic [COST_WIDTH-1:0] out_v,
  output logic                  out_prob_enable,
  input  logic                  in_accept,
  output logic                  out_commit,
  output logic                  out_busy,
  output logic                  out_done,
  output logic                  out_solved,
  output logic [ITER_WIDTH-1:0] out_iter_count
);
  state_t state, state_nxt;
  logic [COST_WIDTH-1:0] cost_reg, v_reg;
  logic start_ok, cost_zero, init_zero, at_limit;
  assign start_ok  = in_start && (state == S_IDLE || state == S_DONE);
  assign cost_zero = cost_reg == COST_WIDTH'(COST_SOLVED);
  assign init_zero = in_initial_cost == COST_WIDTH'(COST_SOLVED);
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) state <= S_IDLE;
    else state <= state_nxt;
  end
  // abort outranks start, and start outranks the normal sequence
  always_comb begin
    state_nxt = state;
    if (in_abort) state_nxt = S_IDLE;
    else if (start_ok) state_nxt = (init_zero || in_max_iter == '0) ? S_DONE : S_REQUEST;
    else begin
      case (state)
        S_IDLE:    state_nxt = S_IDLE;
        S_REQUEST: state_nxt = in_sample_valid ? S_DECIDE : S_REQUEST;
        S_DECIDE:  state_nxt = S_EVAL;
        S_EVAL:    state_nxt = S_CHECK;
        S_CHECK:   state_nxt = (cost_zero || at_limit) ? S_DONE : S_REQUEST;
        S_DONE:    state_nxt = S_DONE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      cost_reg <= '0;
      v_reg <= '0;
      out_commit <= 1'b0;
      out_solved <= 1'b0;
    end else begin
      out_commit <= !in_abort && state == S_EVAL && in_accept;
      if (in_abort) begin
        out_solved <= 1'b0;
      end else if (start_ok) begin
        cost_reg <= in_initial_cost;
        out_solved <= init_zero;
      end else begin
        if (state == S_REQUEST && in_sample_valid) v_reg <= in_proposed_cost;
        if (state == S_EVAL && in_accept) cost_reg <= v_reg;
        if (state == S_CHECK) out_solved <= cost_zero;
      end
    end
  end
  search_iteration_counter #(.W(ITER_WIDTH)) u_counter (
    .clk      (in_clock),
    .rst_n    (in_reset_n),
    .load     (start_ok && !in_abort),
    .inc      (state == S_EVAL && !in_abort),
    .limit    (in_max_iter),
    .count    (out_iter_count),
    .at_limit (at_limit)
  );
  assign out_sample_req  = state == S_REQUEST;
  assign out_prob_enable = state == S_DECIDE;
  assign out_busy        = !(state == S_IDLE || state == S_DONE);
  assign out_done        = state == S_DONE;
  assign out_u           = cost_reg;
  assign out_v           = v_reg;
endmodule
